// File: rtl/my_svi_pkg.sv
// Shared types and constants for the my_svi responder: FSM state encoding,
// 8-bit address/data types and the width of the WAIT down-counter.
package my_svi_pkg;

  typedef logic [7:0] addr_t;
  typedef logic [7:0] data_t;

  localparam int WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/my_svi_if.sv
// my_svi request/response bus: a master issues single-beat register
// requests and the responder returns exactly one response per request.
interface my_svi;
  import my_svi_pkg::*;

  // Both channels use strict valid/ready: a beat transfers on a rising edge
  // where valid && ready; valid never waits on ready, and payload holds
  // stable while valid is high and ready is low.
  logic  req_valid;
  logic  req_ready;
  logic  req_write;
  addr_t req_addr;
  data_t req_wdata;

  logic  rsp_valid;
  logic  rsp_ready;
  data_t rsp_rdata;
  logic  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/my_svi_resp_regfile.sv
// NUM_REGS x 8 register array with one synchronous write port and one
// combinational read port; every location clears on reset.
module my_svi_resp_regfile
  import my_svi_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  data_t         wdata,
  input  logic [AW-1:0] raddr,
  output data_t         rdata
);

  data_t mem_q [NUM_REGS];
  data_t mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/my_svi_responder.sv
// Register-file responder on the my_svi bus: IDLE -> (WAIT) -> RESP -> IDLE.
// Optional MY_SVI_RESP_ERR_EN flags addresses >= NUM_REGS with rsp_err.
module my_svi_responder
  import my_svi_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  my_svi.slave       my_svi_port,
  output logic [7:0] count,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int        AW        = $clog2(NUM_REGS);
  localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_CYCLES);

  state_t        state_q, state_d;
  wait_cnt_t     wcnt_q, wcnt_d;
  logic          write_q, write_d;
  addr_t         addr_q, addr_d;
  data_t         wdata_q, wdata_d;
  data_t         rdata_q, rdata_d;
  logic [7:0]    count_q, count_d;

  logic          accept;
  logic          rsp_hs;
  logic          enter_resp;
  logic          cur_write;
  addr_t         cur_addr;
  data_t         cur_wdata;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic          rf_we;
  data_t         rf_rdata;

  assign accept = my_svi_port.req_valid && my_svi_port.req_ready;
  assign rsp_hs = (state_q == ST_RESP) && my_svi_port.rsp_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q <= wait_cnt_t'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // req_ready is also gated by reset so nothing looks acceptable while held.
  always_comb begin
    my_svi_port.req_ready = 1'b0;
    my_svi_port.rsp_valid = 1'b0;
    busy                  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        my_svi_port.req_ready = reset && start;
        busy                  = 1'b0;
      end
      ST_RESP: my_svi_port.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state  = state_q;
  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

  // With zero wait, RESP is entered on the acceptance edge itself, so the
  // live request fields are used instead of the not-yet-captured copies.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (accept) begin
      cur_write = my_svi_port.req_write;
      cur_addr  = my_svi_port.req_addr;
      cur_wdata = my_svi_port.req_wdata;
    end
  end

  assign cur_idx = cur_addr[AW-1:0];

`ifdef MY_SVI_RESP_ERR_EN
  logic err_q, err_d;

  assign cur_err = ({1'b0, cur_addr} >= 9'(NUM_REGS));

  always_comb begin
    err_d = err_q;
    if (enter_resp) begin
      err_d = cur_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign my_svi_port.rsp_err = err_q;
`else
  logic unused_addr;

  assign cur_err             = 1'b0;
  assign unused_addr         = ^cur_addr;
  assign my_svi_port.rsp_err = 1'b0;
`endif

  assign rf_we = enter_resp && cur_write && !cur_err;

  my_svi_resp_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (rf_rdata)
  );

  // ---------------- datapath ----------------
  always_comb begin
    wcnt_d  = wcnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;

    if (accept) begin
      wcnt_d  = WAIT_LOAD;
      write_d = my_svi_port.req_write;
      addr_d  = my_svi_port.req_addr;
      wdata_d = my_svi_port.req_wdata;
    end else if (state_q == ST_WAIT) begin
      wcnt_d = wcnt_q - wait_cnt_t'(1);
    end

    if (enter_resp) begin
      rdata_d = (cur_write || cur_err) ? '0 : rf_rdata;
    end

    if (rsp_hs) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  assign my_svi_port.rsp_rdata = rdata_q;
  assign count                 = count_q;

endmodule
